// File: rtl/llc_ctrl_regs_param.sv
// ---------------------------------------------------------------------------
// llc_ctrl_regs_param
//
// Control/status register bank that sits beside the LLC input decoder and
// process FSM. It turns their one-cycle trigger pulses into registered state:
//   - an MSHR free-entry counter that refuses to underflow or overflow and
//     records each refused attempt in a sticky error flag,
//   - a vector of independent set/clear stall flags,
//   - a saturating stall-age watchdog fed by a masked subset of the flags.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   mshr_alloc      pulse, one MSHR entry consumed
//   mshr_free       pulse, one MSHR entry returned
//   flag_set        per-bit set request for the flag vector
//   flag_clr        per-bit clear request (wins over flag_set)
//   err_clr         clears both sticky MSHR error flags
//   age_thresh      watchdog threshold, 0 disables the watchdog
//   mshr_cnt        free MSHR entries
//   mshr_empty      no MSHR entry free
//   mshr_all_free   every MSHR entry free
//   flags           registered flag vector
//   mshr_underflow  sticky, alloc attempted while no entry was free
//   mshr_overflow   sticky, free attempted while all entries were free
//   stall_age       consecutive cycles with any masked flag set
//   stall_timeout   registered, stall_age has reached a non-zero age_thresh
// ---------------------------------------------------------------------------
module llc_ctrl_regs_param #(
  parameter int                 N_MSHR     = 16,
  parameter int                 CNT_W      = $clog2(N_MSHR + 1),
  parameter int                 N_FLAGS    = 3,
  parameter logic [N_FLAGS-1:0] STALL_MASK = {N_FLAGS{1'b1}},
  parameter int                 AGE_W      = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mshr_alloc,
  input  logic               mshr_free,
  input  logic [N_FLAGS-1:0] flag_set,
  input  logic [N_FLAGS-1:0] flag_clr,
  input  logic               err_clr,
  input  logic [AGE_W-1:0]   age_thresh,
  output logic [CNT_W-1:0]   mshr_cnt,
  output logic               mshr_empty,
  output logic               mshr_all_free,
  output logic [N_FLAGS-1:0] flags,
  output logic               mshr_underflow,
  output logic               mshr_overflow,
  output logic [AGE_W-1:0]   stall_age,
  output logic               stall_timeout
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_MSHR);
  localparam logic [AGE_W-1:0] AGE_MAX  = {AGE_W{1'b1}};

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               uf_q, uf_d;
  logic               of_q, of_d;
  logic [N_FLAGS-1:0] flags_q, flags_d;
  logic [AGE_W-1:0]   age_q, age_d;
  logic               to_q, to_d;
  logic               stalled;

  // Next-state logic for the MSHR counter and its sticky errors.
  // A simultaneous alloc and free cancel out, even at the counter limits.
  // err_clr is applied first so a same-cycle error event re-sets the flag.
  always_comb begin
    cnt_d = cnt_q;
    uf_d  = err_clr ? 1'b0 : uf_q;
    of_d  = err_clr ? 1'b0 : of_q;
    if (mshr_alloc && !mshr_free) begin
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      else             uf_d  = 1'b1;
    end else if (mshr_free && !mshr_alloc) begin
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CNT_W'(1);
      else                   of_d  = 1'b1;
    end
  end

  // Flag vector: clear has priority over set, untouched bits hold.
  always_comb begin
    flags_d = (flags_q | flag_set) & ~flag_clr;
  end

  // Watchdog looks at the registered flags, so age starts counting the
  // edge after a masked flag becomes visible. The age saturates rather than
  // wrapping so a very long stall can never look like a fresh one.
  always_comb begin
    stalled = |(flags_q & STALL_MASK);
    age_d   = '0;
    if (stalled) age_d = (age_q == AGE_MAX) ? age_q : age_q + AGE_W'(1);
    to_d    = (age_thresh != '0) && (age_d >= age_thresh);
  end

  // All state registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= CNT_FULL;
      uf_q    <= 1'b0;
      of_q    <= 1'b0;
      flags_q <= '0;
      age_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      uf_q    <= uf_d;
      of_q    <= of_d;
      flags_q <= flags_d;
      age_q   <= age_d;
      to_q    <= to_d;
    end
  end

  assign mshr_cnt       = cnt_q;
  assign mshr_empty     = (cnt_q == '0);
  assign mshr_all_free  = (cnt_q == CNT_FULL);
  assign flags          = flags_q;
  assign mshr_underflow = uf_q;
  assign mshr_overflow  = of_q;
  assign stall_age      = age_q;
  assign stall_timeout  = to_q;

endmodule

// File: tb/tb_llc_ctrl_regs_param.sv
// ---------------------------------------------------------------------------
// tb_llc_ctrl_regs_param
//
// Bench for llc_ctrl_regs_param with N_MSHR=4, three flags of which only
// flags 0 and 1 feed the watchdog, and a 3-bit stall-age counter. A
// reference model tracks the expected register state with plain integers
// and is compared against the DUT on every falling edge; directed literal
// checks after each step pin the model to hand-worked values.
// ---------------------------------------------------------------------------
module tb_llc_ctrl_regs_param;

  localparam int N_MSHR = 4;
  localparam int CNT_W  = 3;
  localparam int N_FLAGS = 3;
  localparam int AGE_W  = 3;
  localparam int MASK   = 3'b011;
  localparam int AGE_MAX = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               mshrAlloc = 1'b0;
  logic               mshrFree = 1'b0;
  logic [N_FLAGS-1:0] flagSet = '0;
  logic [N_FLAGS-1:0] flagClr = '0;
  logic               errClr = 1'b0;
  logic [AGE_W-1:0]   ageThresh = '0;
  logic [CNT_W-1:0]   mshrCnt;
  logic               mshrEmpty;
  logic               mshrAllFree;
  logic [N_FLAGS-1:0] flagsOut;
  logic               mshrUnderflow;
  logic               mshrOverflow;
  logic [AGE_W-1:0]   stallAge;
  logic               stallTimeout;

  int errors = 0;
  int checks = 0;

  // Reference state, reset values from the start.
  int mCnt = N_MSHR;
  int mFlags = 0;
  int mAge = 0;
  bit mUf = 1'b0;
  bit mOf = 1'b0;
  bit mTo = 1'b0;
  bit mStalled;

  llc_ctrl_regs_param #(
    .N_MSHR(N_MSHR),
    .N_FLAGS(N_FLAGS),
    .STALL_MASK(3'b011),
    .AGE_W(AGE_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mshr_alloc(mshrAlloc),
    .mshr_free(mshrFree),
    .flag_set(flagSet),
    .flag_clr(flagClr),
    .err_clr(errClr),
    .age_thresh(ageThresh),
    .mshr_cnt(mshrCnt),
    .mshr_empty(mshrEmpty),
    .mshr_all_free(mshrAllFree),
    .flags(flagsOut),
    .mshr_underflow(mshrUnderflow),
    .mshr_overflow(mshrOverflow),
    .stall_age(stallAge),
    .stall_timeout(stallTimeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: counter with limits, sticky errors, flag set/clear and
  // a saturating age counter driven by the flags as they were before the edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt = N_MSHR; mFlags = 0; mAge = 0;
      mUf = 1'b0; mOf = 1'b0; mTo = 1'b0;
    end else begin
      mStalled = (mFlags & MASK) != 0;
      if (errClr) begin
        mUf = 1'b0;
        mOf = 1'b0;
      end
      if (mshrAlloc && !mshrFree) begin
        if (mCnt > 0) mCnt = mCnt - 1;
        else mUf = 1'b1;
      end else if (mshrFree && !mshrAlloc) begin
        if (mCnt < N_MSHR) mCnt = mCnt + 1;
        else mOf = 1'b1;
      end
      mFlags = (mFlags | int'(flagSet)) & ~int'(flagClr) & 7;
      if (!mStalled) mAge = 0;
      else if (mAge < AGE_MAX) mAge = mAge + 1;
      mTo = (ageThresh != 0) && (mAge >= int'(ageThresh));
    end
  end

  // Continuous comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    checkOutput("cnt", int'(mshrCnt), mCnt);
    checkOutput("empty", int'(mshrEmpty), int'(mCnt == 0));
    checkOutput("all_free", int'(mshrAllFree), int'(mCnt == N_MSHR));
    checkOutput("flags", int'(flagsOut), mFlags);
    checkOutput("underflow", int'(mshrUnderflow), int'(mUf));
    checkOutput("overflow", int'(mshrOverflow), int'(mOf));
    checkOutput("stall_age", int'(stallAge), mAge);
    checkOutput("stall_timeout", int'(stallTimeout), int'(mTo));
  end

  // Drive one cycle of triggers, let one rising edge take them, then
  // return 1 time unit later so callers can check the new state.
  task automatic applyStimulus(input bit a, input bit f, input bit [2:0] s,
                               input bit [2:0] c, input bit e);
    mshrAlloc = a;
    mshrFree  = f;
    flagSet   = s;
    flagClr   = c;
    errClr    = e;
    @(posedge clk);
    #1;
    mshrAlloc = 1'b0;
    mshrFree  = 1'b0;
    flagSet   = '0;
    flagClr   = '0;
    errClr    = 1'b0;
  endtask

  initial begin
    // Reset state.
    #12;
    checkOutput("rst_cnt", int'(mshrCnt), 4);
    checkOutput("rst_all_free", int'(mshrAllFree), 1);
    checkOutput("rst_empty", int'(mshrEmpty), 0);
    checkOutput("rst_flags", int'(flagsOut), 0);
    checkOutput("rst_age", int'(stallAge), 0);
    rst = 1'b0;

    // Drain all entries, then one alloc too many.
    for (int i = 3; i >= 0; i--) begin
      applyStimulus(1, 0, 3'b000, 3'b000, 0);
      checkOutput("alloc_cnt", int'(mshrCnt), i);
    end
    checkOutput("empty_at_0", int'(mshrEmpty), 1);
    applyStimulus(1, 0, 3'b000, 3'b000, 0);
    checkOutput("underflow_cnt", int'(mshrCnt), 0);
    checkOutput("underflow_set", int'(mshrUnderflow), 1);
    applyStimulus(0, 0, 3'b000, 3'b000, 1);
    checkOutput("underflow_clr", int'(mshrUnderflow), 0);

    // Alloc and free together at zero cancel without error.
    applyStimulus(1, 1, 3'b000, 3'b000, 0);
    checkOutput("both_at_0_cnt", int'(mshrCnt), 0);
    checkOutput("both_at_0_uf", int'(mshrUnderflow), 0);

    // Refill, then one free too many; err_clr loses to a new event.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 3'b000, 3'b000, 0);
      checkOutput("free_cnt", int'(mshrCnt), i);
    end
    applyStimulus(0, 1, 3'b000, 3'b000, 0);
    checkOutput("overflow_cnt", int'(mshrCnt), 4);
    checkOutput("overflow_set", int'(mshrOverflow), 1);
    applyStimulus(0, 1, 3'b000, 3'b000, 1);
    checkOutput("overflow_wins_clr", int'(mshrOverflow), 1);
    applyStimulus(1, 1, 3'b000, 3'b000, 1);
    checkOutput("overflow_clr", int'(mshrOverflow), 0);
    checkOutput("both_at_full_cnt", int'(mshrCnt), 4);

    // Clear beats set on the same bit.
    applyStimulus(0, 0, 3'b011, 3'b001, 0);
    checkOutput("flags_set_clr", int'(flagsOut), 2);
    applyStimulus(0, 0, 3'b000, 3'b010, 0);
    checkOutput("flags_clr", int'(flagsOut), 0);
    checkOutput("age_after_one_stall", int'(stallAge), 1);
    applyStimulus(0, 0, 3'b000, 3'b000, 0);
    checkOutput("age_idle", int'(stallAge), 0);

    // Watchdog with threshold 5.
    ageThresh = 3'd5;
    applyStimulus(0, 0, 3'b001, 3'b000, 0);
    checkOutput("wd_age_start", int'(stallAge), 0);
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(0, 0, 3'b000, 3'b000, 0);
      checkOutput("wd_age", int'(stallAge), i);
      checkOutput("wd_timeout", int'(stallTimeout), int'(i == 5));
    end
    applyStimulus(0, 0, 3'b000, 3'b001, 0);
    checkOutput("wd_age_on_clr", int'(stallAge), 6);
    checkOutput("wd_to_on_clr", int'(stallTimeout), 1);
    applyStimulus(0, 0, 3'b000, 3'b000, 0);
    checkOutput("wd_age_cleared", int'(stallAge), 0);
    checkOutput("wd_to_cleared", int'(stallTimeout), 0);

    // Flag 2 is outside the watchdog mask.
    applyStimulus(0, 0, 3'b100, 3'b000, 0);
    applyStimulus(0, 0, 3'b000, 3'b000, 0);
    applyStimulus(0, 0, 3'b000, 3'b000, 0);
    checkOutput("mask_flags", int'(flagsOut), 4);
    checkOutput("mask_age", int'(stallAge), 0);
    applyStimulus(0, 0, 3'b000, 3'b100, 0);

    // Saturation with the watchdog disabled, then enabled at the top.
    ageThresh = 3'd0;
    applyStimulus(0, 0, 3'b001, 3'b000, 0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 3'b000, 3'b000, 0);
    checkOutput("sat_age", int'(stallAge), 7);
    checkOutput("sat_to_disabled", int'(stallTimeout), 0);
    ageThresh = 3'd7;
    applyStimulus(0, 0, 3'b000, 3'b000, 0);
    checkOutput("sat_to_enabled", int'(stallTimeout), 1);
    checkOutput("sat_age_hold", int'(stallAge), 7);

    // Reset in the middle of a stall with errors and a non-full counter.
    applyStimulus(0, 1, 3'b000, 3'b000, 0);
    applyStimulus(1, 0, 3'b000, 3'b000, 0);
    checkOutput("pre_rst_cnt", int'(mshrCnt), 3);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_cnt", int'(mshrCnt), 4);
    checkOutput("mid_rst_flags", int'(flagsOut), 0);
    checkOutput("mid_rst_age", int'(stallAge), 0);
    checkOutput("mid_rst_to", int'(stallTimeout), 0);
    checkOutput("mid_rst_of", int'(mshrOverflow), 0);
    applyStimulus(1, 0, 3'b001, 3'b000, 0);
    checkOutput("held_rst_cnt", int'(mshrCnt), 4);
    rst = 1'b0;
    applyStimulus(1, 0, 3'b000, 3'b000, 0);
    checkOutput("post_rst_cnt", int'(mshrCnt), 3);
    checkOutput("post_rst_flags", int'(flagsOut), 0);
    applyStimulus(0, 0, 3'b000, 3'b000, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
